// File: rtl/cdm_share_arbiter_if.sv
// Bundle between the issuing units, the shared-multiplier controller and the multiplier datapath.
// slave = controller side, master = environment (requesters, multiplier, response consumer).
interface cdm_share_arbiter_if #(
  parameter int WIDTH = 8
);
  logic                   req0_valid;
  logic                   req0_ready;
  logic [WIDTH-1:0]       req0_a;
  logic [WIDTH-1:0]       req0_b;
  logic                   req1_valid;
  logic                   req1_ready;
  logic [WIDTH-1:0]       req1_a;
  logic [WIDTH-1:0]       req1_b;
  logic [WIDTH-1:0]       mul_a;
  logic [WIDTH-1:0]       mul_b;
  logic [2*WIDTH-1:0]     mul_r;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [2*WIDTH-1:0]     rsp_r;
  logic                   rsp_id;
  logic                   busy;
  logic [15:0]            ops_done;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mul_r, rsp_ready,
    output req0_ready, req1_ready, mul_a, mul_b, rsp_valid, rsp_r, rsp_id, busy, ops_done
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mul_r, rsp_ready,
    input  req0_ready, req1_ready, mul_a, mul_b, rsp_valid, rsp_r, rsp_id, busy, ops_done
  );
endinterface

// File: rtl/cdm_share_arbiter.sv
// Round-robin time-share of one combinational multiplier; response CALC_CYCLES edges after accept.
// rsp_ready low parks the block in RESP and both requesters see ready=0 until the handshake.
module cdm_share_arbiter #(
  parameter int WIDTH       = 8,
  parameter int CALC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  cdm_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 last_grant;
  logic [3:0]           cnt;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   r_q;
  logic                 id_q;
  logic [15:0]          ops_q;
  logic                 grant_vld;
  logic                 grant;
  logic                 accept;
  logic                 rsp_fire;

  // Ties go to whichever requester was not served last.
  always_comb begin
    grant_vld = bus.req0_valid | bus.req1_valid;
    grant     = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    rsp_fire       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_vld) begin
          accept         = 1'b1;
          bus.req0_ready = ~grant;
          bus.req1_ready = grant;
          state_nxt      = CALC;
        end
      end
      CALC: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      id_q       <= 1'b0;
      ops_q      <= '0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q        <= grant ? bus.req1_a : bus.req0_a;
        b_q        <= grant ? bus.req1_b : bus.req0_b;
        id_q       <= grant;
        last_grant <= grant;
        cnt        <= 4'(CALC_CYCLES - 1);
      end
      // Operands are held for the whole CALC window; the product is sampled on its last edge.
      if (state == CALC) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          r_q <= bus.mul_r;
        end
      end
      if (rsp_fire) begin
        ops_q <= ops_q + 16'd1;
      end
    end
  end

  assign bus.mul_a     = a_q;
  assign bus.mul_b     = b_q;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_r     = r_q;
  assign bus.rsp_id    = id_q;
  assign bus.busy      = (state != IDLE);
  assign bus.ops_done  = ops_q;

endmodule

// File: tb/tb_cdm_share_arbiter.sv
// Bench for cdm_share_arbiter: vector table, hand-written corner sequences and a randomized run
// against a transaction-level model; dut1 uses CALC_CYCLES=1, dut4 uses CALC_CYCLES=4.
module tb_cdm_share_arbiter;

  logic clk;
  logic rst1;
  logic rst4;
  int   total;
  int   bad;

  cdm_share_arbiter_if #(.WIDTH(8)) bus1 ();
  cdm_share_arbiter_if #(.WIDTH(8)) bus4 ();

  assign bus1.mul_r = {8'h00, bus1.mul_a} * {8'h00, bus1.mul_b};
  assign bus4.mul_r = {8'h00, bus4.mul_a} * {8'h00, bus4.mul_b};

  cdm_share_arbiter #(.WIDTH(8), .CALC_CYCLES(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  cdm_share_arbiter #(.WIDTH(8), .CALC_CYCLES(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        v0;
    logic [7:0]  a0;
    logic [7:0]  b0;
    logic        v1;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic        rr;
    logic        rdy0;
    logic        rdy1;
    logic        rv;
    logic [15:0] r;
    logic        id;
    logic        busy;
    logic [15:0] ops;
    logic [7:0]  ma;
    logic [7:0]  mb;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic rst, logic v0, logic [7:0] a0, logic [7:0] b0,
                              logic v1, logic [7:0] a1, logic [7:0] b1, logic rr,
                              logic rdy0, logic rdy1, logic rv, logic [15:0] r, logic id,
                              logic busy, logic [15:0] ops, logic [7:0] ma, logic [7:0] mb);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.a0 = a0; v.b0 = b0; v.v1 = v1; v.a1 = a1; v.b1 = b1; v.rr = rr;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.rv = rv; v.r = r; v.id = id; v.busy = busy; v.ops = ops;
    v.ma = ma; v.mb = mb;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive1(logic r, logic v0, logic [7:0] a0, logic [7:0] b0,
                        logic v1, logic [7:0] a1, logic [7:0] b1, logic rr);
    rst1            = r;
    bus1.req0_valid = v0;
    bus1.req0_a     = a0;
    bus1.req0_b     = b0;
    bus1.req1_valid = v1;
    bus1.req1_a     = a1;
    bus1.req1_b     = b1;
    bus1.rsp_ready  = rr;
  endtask

  task automatic reset1();
    @(negedge clk);
    drive1(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    rst1 = 1'b0;
  endtask

  // Transaction-level model: a response becomes visible CALC_CYCLES+1 cycles after the accept cycle.
  task automatic run_random(int n);
    bit          inflight;
    int          resp_at;
    int          last;
    int          g;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [15:0] prod;
    logic [15:0] r_shown;
    logic        eid;
    logic [15:0] ops;
    logic        exp_rv;
    logic        v0;
    logic        v1;
    inflight = 0; resp_at = 0; last = 1; ea = 0; eb = 0; prod = 0; r_shown = 0; eid = 0; ops = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      drive1(1'b0, v0, 8'($urandom), 8'($urandom), v1, 8'($urandom), 8'($urandom),
             1'($urandom_range(0, 3) != 0));
      #1;
      g = -1;
      if (!inflight) begin
        if (v0 && v1)  g = (last == 1) ? 0 : 1;
        else if (v0)   g = 0;
        else if (v1)   g = 1;
      end
      exp_rv = inflight && (c >= resp_at);
      if (exp_rv) r_shown = prod;
      chk($sformatf("rnd%0d rdy0", c), 32'(bus1.req0_ready), 32'(g == 0));
      chk($sformatf("rnd%0d rdy1", c), 32'(bus1.req1_ready), 32'(g == 1));
      chk($sformatf("rnd%0d rsp_valid", c), 32'(bus1.rsp_valid), 32'(exp_rv));
      chk($sformatf("rnd%0d rsp_r", c), 32'(bus1.rsp_r), 32'(r_shown));
      chk($sformatf("rnd%0d rsp_id", c), 32'(bus1.rsp_id), 32'(eid));
      chk($sformatf("rnd%0d busy", c), 32'(bus1.busy), 32'(inflight));
      chk($sformatf("rnd%0d ops", c), 32'(bus1.ops_done), 32'(ops));
      chk($sformatf("rnd%0d mul_a", c), 32'(bus1.mul_a), 32'(ea));
      chk($sformatf("rnd%0d mul_b", c), 32'(bus1.mul_b), 32'(eb));
      if (g >= 0) begin
        inflight = 1;
        resp_at  = c + 1 + 1;
        ea       = (g == 1) ? bus1.req1_a : bus1.req0_a;
        eb       = (g == 1) ? bus1.req1_b : bus1.req0_b;
        prod     = {8'h00, ea} * {8'h00, eb};
        eid      = 1'(g);
        last     = g;
      end else if (exp_rv && bus1.rsp_ready) begin
        inflight = 0;
        ops      = ops + 16'd1;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive1(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    rst4 = 1'b1;
    bus4.req0_valid = 1'b0; bus4.req0_a = 8'h00; bus4.req0_b = 8'h00;
    bus4.req1_valid = 1'b0; bus4.req1_a = 8'h00; bus4.req1_b = 8'h00;
    bus4.rsp_ready  = 1'b1;

    //            rst v0 a0     b0     v1 a1     b1     rr  rdy0 rdy1 rv r         id busy ops ma     mb
    tbl[0]  = mk(0, 1, 8'h0F, 8'h11, 0, 8'h00, 8'h00, 1,  1, 0, 0, 16'h0000, 0, 0, 16'd0, 8'h00, 8'h00);
    tbl[1]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1,  0, 0, 0, 16'h0000, 0, 1, 16'd0, 8'h0F, 8'h11);
    tbl[2]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1,  0, 0, 1, 16'h00FF, 0, 1, 16'd0, 8'h0F, 8'h11);
    tbl[3]  = mk(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1,  0, 0, 0, 16'h00FF, 0, 0, 16'd1, 8'h0F, 8'h11);
    tbl[4]  = mk(0, 1, 8'h12, 8'h34, 1, 8'hFF, 8'hFF, 1,  1, 0, 0, 16'h0000, 0, 0, 16'd0, 8'h00, 8'h00);
    tbl[5]  = mk(0, 1, 8'h12, 8'h34, 1, 8'hFF, 8'hFF, 1,  0, 0, 0, 16'h0000, 0, 1, 16'd0, 8'h12, 8'h34);
    tbl[6]  = mk(0, 1, 8'h12, 8'h34, 1, 8'hFF, 8'hFF, 1,  0, 0, 1, 16'h03A8, 0, 1, 16'd0, 8'h12, 8'h34);
    tbl[7]  = mk(0, 1, 8'h12, 8'h34, 1, 8'hFF, 8'hFF, 1,  0, 1, 0, 16'h03A8, 0, 0, 16'd1, 8'h12, 8'h34);
    tbl[8]  = mk(0, 1, 8'h12, 8'h34, 1, 8'hFF, 8'hFF, 1,  0, 0, 0, 16'h03A8, 1, 1, 16'd1, 8'hFF, 8'hFF);
    tbl[9]  = mk(0, 1, 8'h12, 8'h34, 1, 8'hFF, 8'hFF, 1,  0, 0, 1, 16'hFE01, 1, 1, 16'd1, 8'hFF, 8'hFF);
    tbl[10] = mk(0, 1, 8'h12, 8'h34, 1, 8'hFF, 8'hFF, 1,  1, 0, 0, 16'hFE01, 1, 0, 16'd2, 8'hFF, 8'hFF);
    tbl[11] = mk(0, 1, 8'h12, 8'h34, 1, 8'hFF, 8'hFF, 0,  0, 0, 0, 16'hFE01, 0, 1, 16'd2, 8'h12, 8'h34);
    for (int i = 12; i < 17; i++) begin
      tbl[i] = mk(0, 1, 8'h12, 8'h34, 1, 8'hFF, 8'hFF, 0, 0, 0, 1, 16'h03A8, 0, 1, 16'd2, 8'h12, 8'h34);
    end
    tbl[17] = mk(0, 1, 8'h12, 8'h34, 1, 8'hFF, 8'hFF, 1,  0, 0, 1, 16'h03A8, 0, 1, 16'd2, 8'h12, 8'h34);
    tbl[18] = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1,  0, 0, 0, 16'h03A8, 0, 0, 16'd3, 8'h12, 8'h34);
    tbl[19] = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1,  0, 0, 0, 16'h03A8, 0, 0, 16'd3, 8'h12, 8'h34);

    @(negedge clk);
    @(negedge clk);
    rst4 = 1'b0;
    reset1();

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive1(tbl[i].rst, tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].rr);
      #1;
      chk($sformatf("vec%0d rdy0", i), 32'(bus1.req0_ready), 32'(tbl[i].rdy0));
      chk($sformatf("vec%0d rdy1", i), 32'(bus1.req1_ready), 32'(tbl[i].rdy1));
      chk($sformatf("vec%0d rsp_valid", i), 32'(bus1.rsp_valid), 32'(tbl[i].rv));
      chk($sformatf("vec%0d rsp_r", i), 32'(bus1.rsp_r), 32'(tbl[i].r));
      chk($sformatf("vec%0d rsp_id", i), 32'(bus1.rsp_id), 32'(tbl[i].id));
      chk($sformatf("vec%0d busy", i), 32'(bus1.busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d ops", i), 32'(bus1.ops_done), 32'(tbl[i].ops));
      chk($sformatf("vec%0d mul_a", i), 32'(bus1.mul_a), 32'(tbl[i].ma));
      chk($sformatf("vec%0d mul_b", i), 32'(bus1.mul_b), 32'(tbl[i].mb));
    end

    // Reset during CALC: last grant was req0, so the tie goes to req1, then reset aborts it.
    @(negedge clk);
    drive1(1'b0, 1'b1, 8'h12, 8'h34, 1'b1, 8'hFF, 8'hFF, 1'b1);
    #1;
    chk("midrst grant1", 32'(bus1.req1_ready), 32'd1);
    @(negedge clk);
    drive1(1'b1, 1'b1, 8'h12, 8'h34, 1'b1, 8'hFF, 8'hFF, 1'b1);
    #1;
    chk("midrst in_calc", 32'(bus1.busy), 32'd1);
    @(negedge clk);
    drive1(1'b0, 1'b1, 8'h12, 8'h34, 1'b1, 8'hFF, 8'hFF, 1'b1);
    #1;
    chk("midrst rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("midrst busy", 32'(bus1.busy), 32'd0);
    chk("midrst mul_a", 32'(bus1.mul_a), 32'd0);
    chk("midrst mul_b", 32'(bus1.mul_b), 32'd0);
    chk("midrst ops", 32'(bus1.ops_done), 32'd0);
    chk("midrst tie_rdy0", 32'(bus1.req0_ready), 32'd1);
    chk("midrst tie_rdy1", 32'(bus1.req1_ready), 32'd0);
    @(negedge clk);
    drive1(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("midrst next_ops", 32'(bus1.ops_done), 32'd1);
    chk("midrst next_r", 32'(bus1.rsp_r), 32'h03A8);

    // Counter wrap: preload the completion count instead of running 65535 operations.
    @(negedge clk);
    force dut1.ops_q = 16'hFFFF;
    #1;
    release dut1.ops_q;
    #1;
    chk("wrap preload", 32'(bus1.ops_done), 32'hFFFF);
    @(negedge clk);
    drive1(1'b0, 1'b1, 8'h03, 8'h05, 1'b0, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    drive1(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("wrap ops", 32'(bus1.ops_done), 32'h0000);
    chk("wrap rsp_r", 32'(bus1.rsp_r), 32'h000F);

    // CALC_CYCLES=4: operands held four cycles, response on the fifth cycle after accept.
    @(negedge clk);
    bus4.req1_valid = 1'b1; bus4.req1_a = 8'h80; bus4.req1_b = 8'h02;
    #1;
    chk("cc4 accept", 32'(bus4.req1_ready), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus4.req1_valid = 1'b0; bus4.req1_a = 8'h00; bus4.req1_b = 8'h00;
      #1;
      chk($sformatf("cc4 c%0d mul_a", k), 32'(bus4.mul_a), 32'h80);
      chk($sformatf("cc4 c%0d mul_b", k), 32'(bus4.mul_b), 32'h02);
      chk($sformatf("cc4 c%0d rsp_valid", k), 32'(bus4.rsp_valid), 32'd0);
      chk($sformatf("cc4 c%0d busy", k), 32'(bus4.busy), 32'd1);
    end
    @(negedge clk);
    #1;
    chk("cc4 rsp_valid", 32'(bus4.rsp_valid), 32'd1);
    chk("cc4 rsp_r", 32'(bus4.rsp_r), 32'h0100);
    chk("cc4 rsp_id", 32'(bus4.rsp_id), 32'd1);
    @(negedge clk);
    #1;
    chk("cc4 idle", 32'(bus4.busy), 32'd0);
    chk("cc4 ops", 32'(bus4.ops_done), 32'd1);
    chk("cc4 mul_a_kept", 32'(bus4.mul_a), 32'h80);

    reset1();
    run_random(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdm_share_arbiter.md
Name: cdm_share_arbiter

Overview:
- Controller that time-shares one 8x8 carry-disregard approximate multiplier between two requesters.
- Arbitrates round-robin and registers the operands that drive the multiplier.
- Holds the operands for a programmable number of settling cycles, then captures the 16-bit product.
- Returns the product on a valid/ready response channel tagged with the requester id.
- Sits between the issuing units and the combinational multiplier datapath.

Parameters:
- WIDTH, 8, operand width; the product is 2*WIDTH bits.
- CALC_CYCLES, 1, cycles mul_a/mul_b are held before mul_r is captured; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_a  input  WIDTH  requester 0 multiplicand.
- req0_b  input  WIDTH  requester 0 multiplier.
- req1_valid, req1_ready, req1_a, req1_b  same as requester 0, for requester 1.
- mul_a  output  WIDTH  registered operand A to the shared multiplier.
- mul_b  output  WIDTH  registered operand B to the shared multiplier.
- mul_r  input  2*WIDTH  combinational product from the shared multiplier.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_r  output  2*WIDTH  captured product.
- rsp_id  output  1  requester that issued the result.
- busy  output  1  high in CALC or RESP.
- ops_done  output  16  completed responses; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, mul_a=0, mul_b=0, rsp_r=0, rsp_id=0, rsp_valid=0, busy=0, ops_done=0, last_grant=1.
  - Reset mid-operation aborts the operation; no response is produced.
- States: IDLE, CALC, RESP.
- Grant is computed combinationally in IDLE:
  - Only one valid: grant that requester.
  - Both valid: grant the requester != last_grant.
  - Neither valid: no grant.
- reqK_ready = (state==IDLE) && reqK_valid && grant==K.
  - At most one ready per cycle; ready is 0 in CALC and RESP.
- IDLE -> CALC on an accept edge:
  - mul_a, mul_b <= granted operands; rsp_id, last_grant <= grant; cnt <= CALC_CYCLES-1.
- CALC:
  - cnt != 0: cnt decrements.
  - cnt == 0: rsp_r <= mul_r, go to RESP.
  - mul_a/mul_b are stable throughout CALC.
- RESP:
  - rsp_valid=1.
  - rsp_r and rsp_id are held stable until handshake.
  - On rsp_valid && rsp_ready: go to IDLE, ops_done increments.
- Latency:
  - rsp_valid rises CALC_CYCLES edges after the accept edge.
  - Minimum issue interval is CALC_CYCLES+2 cycles, because one IDLE cycle is mandatory between operations.
- mul_a/mul_b keep their last operands after completion; they change only on accept or reset.
- A requester that drops valid without a handshake loses nothing; no state change.
- Back-pressure: rsp_ready low holds RESP indefinitely and both requesters see ready=0.
- busy = (state != IDLE).
- No arithmetic is done in this block; mul_r is passed through bit-exact, whatever approximation the multiplier applies.
- The CALC_CYCLES=1 default assumes the multiplier fits in one clock; larger values cover multicycle timing.

Test Plan:
- Bench stub: mul_r = mul_a*mul_b exact.
- Single requester, CALC_CYCLES=1: req0 a=0x0F b=0x11, rsp_ready=1 -> req0_ready one cycle; rsp_valid 1 edge later; rsp_r=0x00FF, rsp_id=0; ops_done=1.
- Simultaneous requests after reset: req0 (0x12,0x34) and req1 (0xFF,0xFF) held valid -> req0 served first (rsp_r=0x03A8, id 0), then req1 (rsp_r=0xFE01, id 1), then req0 again; grants alternate.
- Back-pressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_r, rsp_id stable; req0_ready/req1_ready=0; after rsp_ready=1, IDLE next cycle; ops_done increments once.
- CALC_CYCLES=4: req1 a=0x80 b=0x02 -> mul_a=0x80, mul_b=0x02 stable 4 cycles; rsp_valid 4 edges after accept; rsp_r=0x0100.
- Reset mid-op: rst asserted in CALC -> next cycle rsp_valid=0, busy=0, mul_a=mul_b=0, ops_done=0; the next tie grants req0.
- Wrap: preload via 65535 completed ops (or force) -> one more completion gives ops_done=0x0000.
